alarm_clock_multi: RTL and testbench

Parametrised successor to the single-alarm lab clock. It holds a BCD MM:SS time-of-day counter and NUM_ALARMS independent alarm channels, all programmed by ASCII commands from the UART receive path. Each channel has its own idle/armed/triggered state machine. The block sits between the UART receiver and the display/LED logic. Time loads commit atomically on carriage return, unlike the per-digit loads of the previous generation.

---
 rtl/alarm_clock_multi.sv | 268 ++++++++++++++++++++++++++
 tb/tb_alarm_clock_multi.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_clock_multi.sv
// UART-programmed BCD MM:SS clock with NUM_ALARMS independent alarm channels.
// Optional feature macro ALARM_AUTOCLR_EN: a triggered alarm re-arms after TRIG_SECS strobes.
module alarm_clock_multi #(
    parameter int unsigned NUM_ALARMS = 4,
    parameter int unsigned TRIG_SECS  = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      oneSecStrb,
    input  logic                      bu_rx_data_rdy,
    input  logic [7:0]                bu_rx_data,
    output logic [3:0]                di_Mtens,
    output logic [3:0]                di_Mones,
    output logic [3:0]                di_Stens,
    output logic [3:0]                di_Sones,
    output logic [16*NUM_ALARMS-1:0]  di_alarm_time,
    output logic [NUM_ALARMS-1:0]     alarm_armed,
    output logic [NUM_ALARMS-1:0]     alarm_trig,
    output logic                      any_trig,
    output logic                      dicRun,
    output logic                      cmd_err
);

    if (NUM_ALARMS < 1 || NUM_ALARMS > 9) begin : g_bad_num_alarms
        $error("NUM_ALARMS must be in 1..9");
    end
    if (TRIG_SECS < 1 || TRIG_SECS > 255) begin : g_bad_trig_secs
        $error("TRIG_SECS must be in 1..255");
    end

    localparam logic [7:0] CharL      = 8'h6C;
    localparam logic [7:0] CharA      = 8'h61;
    localparam logic [7:0] CharAt     = 8'h40;
    localparam logic [7:0] CharCr     = 8'h0D;
    localparam logic [7:0] MaxIdxChar = 8'(32'h30 + NUM_ALARMS - 1);

    typedef enum logic [2:0] {
        P_IDLE, P_SEL, P_D0, P_D1, P_D2, P_D3, P_CR
    } pstate_t;

    typedef enum logic [1:0] {
        CH_IDLE, CH_ARMED, CH_TRIG
    } ch_state_t;

    pstate_t     pstate;
    logic        op_tog;
    logic        tgt_time;
    logic [3:0]  tgt_idx;
    logic [15:0] stage;
    logic [15:0] tm;

    logic                  is_d5, is_d9, is_idx, byte_ok;
    logic                  commit, abort;
    logic [NUM_ALARMS-1:0] toggle;

    function automatic logic [15:0] bcd_inc(input logic [15:0] t);
        logic [15:0] n;
        n = t;
        if (t[3:0] != 4'd9) begin
            n[3:0] = t[3:0] + 4'd1;
        end else begin
            n[3:0] = 4'd0;
            if (t[7:4] != 4'd5) begin
                n[7:4] = t[7:4] + 4'd1;
            end else begin
                n[7:4] = 4'd0;
                if (t[11:8] != 4'd9) begin
                    n[11:8] = t[11:8] + 4'd1;
                end else begin
                    n[11:8]  = 4'd0;
                    n[15:12] = (t[15:12] == 4'd5) ? 4'd0 : t[15:12] + 4'd1;
                end
            end
        end
        return n;
    endfunction

    // Byte classification for the current parser state; P_IDLE never flags an error.
    always_comb begin
        is_d5   = (bu_rx_data >= 8'h30) && (bu_rx_data <= 8'h35);
        is_d9   = (bu_rx_data >= 8'h30) && (bu_rx_data <= 8'h39);
        is_idx  = (bu_rx_data >= 8'h30) && (bu_rx_data <= MaxIdxChar);
        byte_ok = 1'b1;
        case (pstate)
            P_SEL:      byte_ok = is_idx;
            P_D0, P_D2: byte_ok = is_d5;
            P_D1, P_D3: byte_ok = is_d9;
            P_CR:       byte_ok = (bu_rx_data == CharCr);
            default:    byte_ok = 1'b1;
        endcase
        abort  = bu_rx_data_rdy && (pstate != P_IDLE) && !byte_ok;
        commit = bu_rx_data_rdy && (pstate == P_CR) && byte_ok;
        toggle = '0;
        for (int k = 0; k < NUM_ALARMS; k++) begin
            toggle[k] = bu_rx_data_rdy && (pstate == P_SEL) && op_tog && is_idx &&
                        (bu_rx_data[3:0] == 4'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pstate   <= P_IDLE;
            op_tog   <= 1'b0;
            tgt_time <= 1'b0;
            tgt_idx  <= '0;
            stage    <= '0;
            cmd_err  <= 1'b0;
            dicRun   <= 1'b1;
        end else begin
            cmd_err <= abort;
            if (abort || commit) begin
                pstate <= P_IDLE;
                dicRun <= 1'b1;
                if (abort) begin
                    stage <= '0;
                end
            end else if (bu_rx_data_rdy) begin
                case (pstate)
                    P_IDLE: begin
                        if (bu_rx_data == CharL) begin
                            tgt_time <= 1'b1;
                            dicRun   <= 1'b0;
                            pstate   <= P_D0;
                        end else if (bu_rx_data == CharA) begin
                            op_tog <= 1'b0;
                            pstate <= P_SEL;
                        end else if (bu_rx_data == CharAt) begin
                            op_tog <= 1'b1;
                            pstate <= P_SEL;
                        end
                    end
                    P_SEL: begin
                        tgt_time <= 1'b0;
                        tgt_idx  <= bu_rx_data[3:0];
                        pstate   <= op_tog ? P_IDLE : P_D0;
                    end
                    P_D0: begin
                        stage[15:12] <= bu_rx_data[3:0];
                        pstate       <= P_D1;
                    end
                    P_D1: begin
                        stage[11:8] <= bu_rx_data[3:0];
                        pstate      <= P_D2;
                    end
                    P_D2: begin
                        stage[7:4] <= bu_rx_data[3:0];
                        pstate     <= P_D3;
                    end
                    P_D3: begin
                        stage[3:0] <= bu_rx_data[3:0];
                        pstate     <= P_CR;
                    end
                    default: pstate <= P_IDLE;
                endcase
            end
        end
    end

    // A time commit takes priority over a coincident strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            tm <= '0;
        end else if (commit && tgt_time) begin
            tm <= stage;
        end else if (oneSecStrb && dicRun) begin
            tm <= bcd_inc(tm);
        end
    end

    assign di_Mtens = tm[15:12];
    assign di_Mones = tm[11:8];
    assign di_Stens = tm[7:4];
    assign di_Sones = tm[3:0];
    assign any_trig = |alarm_trig;

    for (genvar k = 0; k < NUM_ALARMS; k++) begin : g_ch
        ch_state_t   st;
        logic [15:0] atm;
        logic        armed_r, trig_r;
        logic        match, can_trig;

        assign match                     = (tm == atm);
        assign di_alarm_time[16*k +: 16] = atm;
        assign alarm_armed[k]            = armed_r;
        assign alarm_trig[k]             = trig_r;

        always_ff @(posedge clk) begin
            if (rst) begin
                atm <= '0;
            end else if (commit && !tgt_time && (tgt_idx == 4'(k))) begin
                atm <= stage;
            end
        end

`ifdef ALARM_AUTOCLR_EN
        localparam logic [7:0] TrigLast = 8'(TRIG_SECS - 1);
        logic [7:0] cnt;
        logic       hold;
        // After an auto-clear, match must drop before the channel may fire again.
        assign can_trig = match && !hold;
`else
        assign can_trig = match;
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                st      <= CH_IDLE;
                armed_r <= 1'b0;
                trig_r  <= 1'b0;
`ifdef ALARM_AUTOCLR_EN
                cnt     <= '0;
                hold    <= 1'b0;
`endif
            end else begin
`ifdef ALARM_AUTOCLR_EN
                if (!match || toggle[k]) begin
                    hold <= 1'b0;
                end
`endif
                case (st)
                    CH_IDLE: begin
                        if (toggle[k]) begin
                            st      <= CH_ARMED;
                            armed_r <= 1'b1;
                        end
                    end
                    CH_ARMED: begin
                        if (toggle[k]) begin
                            st      <= CH_IDLE;
                            armed_r <= 1'b0;
                        end else if (can_trig) begin
                            st      <= CH_TRIG;
                            armed_r <= 1'b0;
                            trig_r  <= 1'b1;
`ifdef ALARM_AUTOCLR_EN
                            cnt     <= '0;
`endif
                        end
                    end
                    CH_TRIG: begin
                        if (toggle[k]) begin
                            st     <= CH_IDLE;
                            trig_r <= 1'b0;
                        end
`ifdef ALARM_AUTOCLR_EN
                        else if (oneSecStrb) begin
                            if (cnt == TrigLast) begin
                                st      <= CH_ARMED;
                                trig_r  <= 1'b0;
                                armed_r <= 1'b1;
                                hold    <= 1'b1;
                            end else begin
                                cnt <= cnt + 8'd1;
                            end
                        end
`endif
                    end
                    default: begin
                        st      <= CH_IDLE;
                        armed_r <= 1'b0;
                        trig_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alarm_clock_multi.sv
// Self-checking bench for alarm_clock_multi: command vector table plus corner-case sequences.
module tb_alarm_clock_multi;

    localparam int unsigned NA = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            oneSecStrb;
    logic            bu_rx_data_rdy;
    logic [7:0]      bu_rx_data;
    logic [3:0]      di_Mtens, di_Mones, di_Stens, di_Sones;
    logic [16*NA-1:0] di_alarm_time;
    logic [NA-1:0]   alarm_armed, alarm_trig;
    logic            any_trig, dicRun, cmd_err;

    alarm_clock_multi #(
        .NUM_ALARMS(NA),
        .TRIG_SECS (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .oneSecStrb    (oneSecStrb),
        .bu_rx_data_rdy(bu_rx_data_rdy),
        .bu_rx_data    (bu_rx_data),
        .di_Mtens      (di_Mtens),
        .di_Mones      (di_Mones),
        .di_Stens      (di_Stens),
        .di_Sones      (di_Sones),
        .di_alarm_time (di_alarm_time),
        .alarm_armed   (alarm_armed),
        .alarm_trig    (alarm_trig),
        .any_trig      (any_trig),
        .dicRun        (dicRun),
        .cmd_err       (cmd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] exp;
    } sb_t;

    typedef struct {
        string       cmd;
        int          strobe_after;
        int          exp_err;
        logic [15:0] exp_time;
    } vec_t;

    sb_t  sbq[$];
    vec_t vecs[8];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [15:0] tm_now();
        return {di_Mtens, di_Mones, di_Stens, di_Sones};
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input string name, input logic [63:0] exp);
        sb_t s;
        s.name = name;
        s.exp  = exp;
        sbq.push_back(s);
    endtask

    task automatic pop_cmp(input logic [63:0] act);
        sb_t s;
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty: got %h expected an entry", act);
        end else begin
            s = sbq.pop_front();
            cmp(s.name, act, s.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bu_rx_data     = b;
        bu_rx_data_rdy = 1'b1;
        tick();
        bu_rx_data_rdy = 1'b0;
        bu_rx_data     = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
        end
    endtask

    task automatic strobe();
        oneSecStrb = 1'b1;
        tick();
        oneSecStrb = 1'b0;
    endtask

    initial begin
        int errs;

        vecs[0] = '{"l1234\015", 2,  0, 16'h1234};
        vecs[1] = '{"l7",        -1, 1, 16'h1234};
        vecs[2] = '{"l1234x",    3,  1, 16'h1234};
        vecs[3] = '{"zQ!",       -1, 0, 16'h1234};
        vecs[4] = '{"a9",        -1, 1, 16'h1234};
        vecs[5] = '{"l5960\015", -1, 1, 16'h1234};
        vecs[6] = '{"@7",        -1, 1, 16'h1234};
        vecs[7] = '{"l0000\015", 4,  0, 16'h0000};

        rst            = 1'b1;
        oneSecStrb     = 1'b0;
        bu_rx_data_rdy = 1'b0;
        bu_rx_data     = 8'h00;
        tick();
        tick();
        rst = 1'b0;

        cmp("rst_time",   64'(tm_now()), 64'h0);
        cmp("rst_alarms", di_alarm_time, 64'h0);
        cmp("rst_armed",  64'(alarm_armed), 64'h0);
        cmp("rst_trig",   64'(alarm_trig), 64'h0);
        cmp("rst_any",    64'(any_trig), 64'h0);
        cmp("rst_run",    64'(dicRun), 64'h1);
        cmp("rst_err",    64'(cmd_err), 64'h0);

        oneSecStrb = 1'b1;
        for (int i = 0; i < 600; i++) begin
            tick();
        end
        oneSecStrb = 1'b0;
        cmp("count_600", 64'(tm_now()), 64'h1000);

        send_str("l5958\015");
        cmp("load_5958", 64'(tm_now()), 64'h5958);
        oneSecStrb = 1'b1;
        cmp("strobe_not_early", 64'(tm_now()), 64'h5958);
        tick();
        oneSecStrb = 1'b0;
        cmp("inc_5959", 64'(tm_now()), 64'h5959);
        strobe();
        cmp("wrap_0000", 64'(tm_now()), 64'h0000);

        for (int v = 0; v < 8; v++) begin
            push_exp($sformatf("vec%0d_err_pulses", v), 64'(vecs[v].exp_err));
            push_exp($sformatf("vec%0d_time", v), 64'(vecs[v].exp_time));
            errs = 0;
            for (int i = 0; i < vecs[v].cmd.len(); i++) begin
                send_byte(vecs[v].cmd[i]);
                errs += int'(cmd_err);
                if (i == vecs[v].strobe_after) begin
                    cmp($sformatf("vec%0d_run_low", v), 64'(dicRun), 64'h0);
                    strobe();
                    errs += int'(cmd_err);
                end
            end
            tick();
            errs += int'(cmd_err);
            pop_cmp(64'(errs));
            pop_cmp(64'(tm_now()));
            cmp($sformatf("vec%0d_run_end", v), 64'(dicRun), 64'h1);
        end
        cmp("table_alarms_untouched", di_alarm_time, 64'h0);
        cmp("table_armed_untouched", 64'(alarm_armed), 64'h0);

        send_str("a2000");
        cmp("alarm_load_runs", 64'(dicRun), 64'h1);
        send_str("5\015");
        cmp("alarm2_loaded", di_alarm_time, 64'h0000_0005_0000_0000);
        send_str("@2");
        cmp("arm2", 64'(alarm_armed), 64'b0100);
        for (int i = 0; i < 5; i++) begin
            strobe();
        end
        cmp("time_0005", 64'(tm_now()), 64'h0005);
        cmp("trig_not_yet", 64'(alarm_trig), 64'h0);
        tick();
        cmp("trig2", 64'(alarm_trig), 64'b0100);
        cmp("trig2_any", 64'(any_trig), 64'h1);
        cmp("trig2_unarmed", 64'(alarm_armed), 64'h0);

        // Hold time still by opening a load so match stays high while strobes arrive.
        send_byte("l");
        for (int i = 0; i < 3; i++) begin
            strobe();
        end
        tick();
        tick();
        cmp("held_time", 64'(tm_now()), 64'h0005);
`ifdef ALARM_AUTOCLR_EN
        cmp("autoclr_armed", 64'(alarm_armed), 64'b0100);
        cmp("autoclr_no_retrig", 64'(alarm_trig), 64'h0);
`else
        cmp("trig_persists", 64'(alarm_trig), 64'b0100);
        cmp("trig_persists_any", 64'(any_trig), 64'h1);
`endif
        send_byte("x");
        cmp("abort_pulse", 64'(cmd_err), 64'h1);
        tick();
        cmp("abort_pulse_once", 64'(cmd_err), 64'h0);
        send_str("@2");
        cmp("ch2_idle_armed", 64'(alarm_armed), 64'h0);
        cmp("ch2_idle_trig", 64'(alarm_trig), 64'h0);

        send_str("a10010\015");
        send_str("@1");
        cmp("arm1", 64'(alarm_armed), 64'b0010);
        send_str("l0009\015");
        send_byte("@");
        strobe();
        cmp("time_0010", 64'(tm_now()), 64'h0010);
        send_byte("1");
        cmp("toggle_wins_armed", 64'(alarm_armed), 64'h0);
        cmp("toggle_wins_trig", 64'(alarm_trig), 64'h0);
        tick();
        cmp("toggle_wins_hold", 64'(alarm_trig), 64'h0);

        send_str("@1");
        cmp("rearm1", 64'(alarm_armed), 64'b0010);
        tick();
        cmp("level_match_trig1", 64'(alarm_trig), 64'b0010);
        send_str("@1");
        cmp("ch1_idle", 64'(alarm_trig | alarm_armed), 64'h0);

        send_str("@3");
        send_str("l0000\015");
        cmp("load_0000", 64'(tm_now()), 64'h0000);
        tick();
        cmp("load_triggers3", 64'(alarm_trig), 64'b1000);
        send_str("@3");
        cmp("ch3_idle", 64'(alarm_trig | alarm_armed), 64'h0);

        send_str("l4321");
        bu_rx_data     = 8'h0D;
        bu_rx_data_rdy = 1'b1;
        oneSecStrb     = 1'b1;
        tick();
        bu_rx_data_rdy = 1'b0;
        oneSecStrb     = 1'b0;
        cmp("commit_beats_strobe", 64'(tm_now()), 64'h4321);
        cmp("commit_run", 64'(dicRun), 64'h1);
        tick();
        cmp("commit_no_late_inc", 64'(tm_now()), 64'h4321);

        send_str("l12");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmp("midrst_time", 64'(tm_now()), 64'h0);
        cmp("midrst_run", 64'(dicRun), 64'h1);
        cmp("midrst_alarms", di_alarm_time, 64'h0);
        errs = 0;
        for (int i = 0; i < 3; i++) begin
            send_byte((i == 2) ? 8'h0D : 8'(8'h33 + i));
            errs += int'(cmd_err);
        end
        cmp("midrst_idle_no_err", 64'(errs), 64'h0);
        cmp("midrst_idle_time", 64'(tm_now()), 64'h0);
        strobe();
        cmp("midrst_runs", 64'(tm_now()), 64'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
